// File: rtl/hs32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_pkg                                                             |
// | Shared FSM state type, bus-error data word and arbitration helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hs32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } hs32_state_e;

    localparam logic [31:0] HS32_BUS_ERR_DATA = 32'hFFFF_FFFF;

    // Returns 1 when execute wins; prefer_fetch breaks a tie toward fetch.
    function automatic logic hs32_grant_exec(input logic f_req,
                                             input logic e_req,
                                             input logic prefer_fetch);
        return e_req & (~f_req | ~prefer_fetch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_mem_arb                                                         |
// | Fetch/execute memory arbiter with wait timeout and fetch flush.     |
// | Optional macro HS32_ARB_RR_EN: round-robin instead of exec priority.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hs32_mem_arb
    import hs32_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] f_addr,
    input  logic        f_reqm,
    output logic [31:0] f_dtr,
    output logic        f_ackm,
    input  logic        flush,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_dtw,
    input  logic        e_rw,
    input  logic        e_reqm,
    output logic [31:0] e_dtr,
    output logic        e_ackm,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    output logic        m_rw,
    output logic        m_stb,
    input  logic [31:0] m_dtr,
    input  logic        m_ack,
    output logic        bus_err
);

    localparam int            CW         = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    hs32_state_e   r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_cancel, w_cancel;
    logic          r_owner_e, w_owner_e;
    logic          r_tmo, w_tmo;
    logic [31:0]   r_rdata, w_rdata;
    logic [31:0]   w_m_addr, w_m_dtw, w_f_dtr, w_e_dtr;
    logic          w_m_rw, w_m_stb, w_f_ackm, w_e_ackm, w_bus_err;
    logic          w_grant_e, w_prefer_fetch;

`ifdef HS32_ARB_RR_EN
    logic r_last_e, w_last_e;
    // After an execute win, a tie goes to fetch, and vice versa.
    assign w_prefer_fetch = r_last_e;
`else
    assign w_prefer_fetch = 1'b0;
`endif

    assign w_grant_e = hs32_grant_exec(f_reqm, e_reqm, w_prefer_fetch);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_cancel  = r_cancel;
        w_owner_e = r_owner_e;
        w_tmo     = r_tmo;
        w_rdata   = r_rdata;
        w_m_addr  = m_addr;
        w_m_dtw   = m_dtw;
        w_m_rw    = m_rw;
        w_m_stb   = m_stb;
        w_f_dtr   = f_dtr;
        w_e_dtr   = e_dtr;
        w_f_ackm  = 1'b0;
        w_e_ackm  = 1'b0;
        w_bus_err = 1'b0;
`ifdef HS32_ARB_RR_EN
        w_last_e  = r_last_e;
`endif
        case (r_state)
            IDLE: begin
                if (f_reqm || e_reqm) begin
                    w_state   = BUSY;
                    w_owner_e = w_grant_e;
                    w_m_stb   = 1'b1;
                    w_cnt     = '0;
                    w_cancel  = 1'b0;
                    w_tmo     = 1'b0;
`ifdef HS32_ARB_RR_EN
                    w_last_e  = w_grant_e;
`endif
                    if (w_grant_e) begin
                        w_m_addr = e_addr;
                        w_m_dtw  = e_dtw;
                        w_m_rw   = e_rw;
                    end else begin
                        w_m_addr = f_addr;
                        w_m_dtw  = '0;
                        w_m_rw   = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (flush && !r_owner_e)
                    w_cancel = 1'b1;
                // m_ack on the final allowed cycle still completes normally.
                if (m_ack) begin
                    w_rdata = m_dtr;
                    w_m_stb = 1'b0;
                    w_state = RESP;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_rdata = HS32_BUS_ERR_DATA;
                    w_tmo   = 1'b1;
                    w_m_stb = 1'b0;
                    w_state = RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_state   = IDLE;
                w_bus_err = r_tmo;
                if (r_owner_e) begin
                    w_e_ackm = 1'b1;
                    w_e_dtr  = r_rdata;
                end else if (!(r_cancel || flush)) begin
                    w_f_ackm = 1'b1;
                    w_f_dtr  = r_rdata;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cancel  <= 1'b0;
            r_owner_e <= 1'b0;
            r_tmo     <= 1'b0;
            r_rdata   <= '0;
            m_addr    <= '0;
            m_dtw     <= '0;
            m_rw      <= 1'b0;
            m_stb     <= 1'b0;
            f_dtr     <= '0;
            e_dtr     <= '0;
            f_ackm    <= 1'b0;
            e_ackm    <= 1'b0;
            bus_err   <= 1'b0;
`ifdef HS32_ARB_RR_EN
            r_last_e  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_cancel  <= w_cancel;
            r_owner_e <= w_owner_e;
            r_tmo     <= w_tmo;
            r_rdata   <= w_rdata;
            m_addr    <= w_m_addr;
            m_dtw     <= w_m_dtw;
            m_rw      <= w_m_rw;
            m_stb     <= w_m_stb;
            f_dtr     <= w_f_dtr;
            e_dtr     <= w_e_dtr;
            f_ackm    <= w_f_ackm;
            e_ackm    <= w_e_ackm;
            bus_err   <= w_bus_err;
`ifdef HS32_ARB_RR_EN
            r_last_e  <= w_last_e;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hs32_mem_arb                                                      |
// | Directed bench with a transaction-timeline model of the arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hs32_mem_arb;

    localparam int WT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] f_addr, e_addr, e_dtw, m_dtr;
    logic        f_reqm, e_reqm, e_rw, flush, m_ack;
    logic [31:0] f_dtr, e_dtr, m_addr, m_dtw;
    logic        f_ackm, e_ackm, m_rw, m_stb, bus_err;

    always #5 clk = ~clk;

    hs32_mem_arb #(.WAIT_TIMEOUT(WT)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_addr(f_addr), .f_reqm(f_reqm), .f_dtr(f_dtr), .f_ackm(f_ackm),
        .flush(flush),
        .e_addr(e_addr), .e_dtw(e_dtw), .e_rw(e_rw), .e_reqm(e_reqm),
        .e_dtr(e_dtr), .e_ackm(e_ackm),
        .m_addr(m_addr), .m_dtw(m_dtw), .m_rw(m_rw), .m_stb(m_stb),
        .m_dtr(m_dtr), .m_ack(m_ack), .bus_err(bus_err)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_delay strobe cycles (-1 = never).
    int          ack_delay = 0;
    logic [31:0] mem_data = '0;
    bit          spurious = 1'b0;
    int          scnt = 0;
    assign m_dtr = mem_data;

    initial begin
        m_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && m_stb) begin
                m_ack = (ack_delay >= 0 && scnt == ack_delay);
                scnt++;
            end else begin
                scnt  = 0;
                m_ack = spurious;
            end
        end
    end

    // Timeline model: a grant at edge g occupies the bus for l cycles and
    // the ack is visible right after edge g+l+1.
    int          cyc, g, l;
    bit          act, own_e, tmo, canc, last_e, ge, cmp_en;
    bit          x_rw;
    logic [31:0] x_addr, x_dtw, edata, mf_dtr, me_dtr;

    initial begin
        cmp_en = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                cyc = 0; act = 0; canc = 0; last_e = 0;
                mf_dtr = '0; me_dtr = '0;
            end else begin
                cyc++;
                if (act && !own_e && flush && cyc > g && cyc <= g + l + 1)
                    canc = 1;
                if (act && cyc == g + l + 1) begin
                    if (own_e) me_dtr = edata;
                    else if (!canc) mf_dtr = edata;
                end
                if ((!act || cyc > g + l + 1) && (f_reqm || e_reqm)) begin
`ifdef HS32_ARB_RR_EN
                    ge = (f_reqm && e_reqm) ? !last_e : e_reqm;
`else
                    ge = e_reqm;
`endif
                    last_e = ge;
                    act = 1; own_e = ge; g = cyc; canc = 0;
                    x_addr = ge ? e_addr : f_addr;
                    x_dtw  = e_dtw;
                    x_rw   = ge ? e_rw : 1'b0;
                    tmo    = !(ack_delay >= 0 && ack_delay < WT);
                    l      = tmo ? WT : ack_delay + 1;
                    edata  = tmo ? 32'hFFFF_FFFF : mem_data;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    bit exp_stb, ack_now;
    initial forever begin
        @(negedge clk);
        if (reset_n && cmp_en) begin
            exp_stb = act && cyc >= g && cyc < g + l;
            ack_now = act && cyc == g + l + 1;
            chk("m_stb",   {31'd0, m_stb},   {31'd0, exp_stb});
            chk("f_ackm",  {31'd0, f_ackm},  {31'd0, ack_now && !own_e && !canc});
            chk("e_ackm",  {31'd0, e_ackm},  {31'd0, ack_now && own_e});
            chk("bus_err", {31'd0, bus_err}, {31'd0, ack_now && tmo});
            chk("f_dtr", f_dtr, mf_dtr);
            chk("e_dtr", e_dtr, me_dtr);
            if (exp_stb) begin
                chk("m_addr", m_addr, x_addr);
                chk("m_rw", {31'd0, m_rw}, {31'd0, x_rw});
                if (own_e) chk("m_dtw", m_dtw, x_dtw);
            end
        end
    end

    // Event counters and requester release on acknowledge.
    int fack_cnt, eack_cnt, berr_cnt, stb_cnt;
    int order[$];
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (f_ackm) begin fack_cnt++; order.push_back(0); f_reqm = 1'b0; end
            if (e_ackm) begin eack_cnt++; order.push_back(1); e_reqm = 1'b0; end
            if (bus_err) berr_cnt++;
            if (m_stb) stb_cnt++;
        end
    end

    task automatic clr();
        fack_cnt = 0; eack_cnt = 0; berr_cnt = 0; stb_cnt = 0;
    endtask

    task automatic wait_ack(input bit is_e, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!(is_e ? e_ackm : f_ackm) && edges < 40);
        if (!(is_e ? e_ackm : f_ackm)) begin
            checks++; errs++;
            $display("FAIL wait_ack: no ack within %0d cycles (exec=%0d)", edges, is_e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_stb"},   {31'd0, m_stb},   32'd0);
        chk({tag, "_m_addr"},  m_addr,           32'd0);
        chk({tag, "_m_dtw"},   m_dtw,            32'd0);
        chk({tag, "_m_rw"},    {31'd0, m_rw},    32'd0);
        chk({tag, "_f_dtr"},   f_dtr,            32'd0);
        chk({tag, "_e_dtr"},   e_dtr,            32'd0);
        chk({tag, "_f_ackm"},  {31'd0, f_ackm},  32'd0);
        chk({tag, "_e_ackm"},  {31'd0, e_ackm},  32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    int n;
    initial begin
        f_addr = '0; e_addr = '0; e_dtw = '0; e_rw = 1'b0;
        f_reqm = 1'b0; e_reqm = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);

        // Fetch read, minimum latency
        clr(); mem_data = 32'hDEAD_BEEF; ack_delay = 0;
        f_addr = 32'h10; f_reqm = 1'b1;
        wait_ack(1'b0, n);
        chk("fetch_latency", n, 3);
        repeat (3) @(negedge clk);
        chk("fetch_ack_once", fack_cnt, 1);
        chk("fetch_no_eack", eack_cnt, 0);
        chk("fetch_dtr", f_dtr, 32'hDEAD_BEEF);
        chk("fetch_stb_cycles", stb_cnt, 1);

        // Execute write, bus held through BUSY
        clr(); mem_data = 32'hCAFE_0001; ack_delay = 2;
        e_addr = 32'h100; e_dtw = 32'h1234_5678; e_rw = 1'b1; e_reqm = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wr_m_rw", {31'd0, m_rw}, 32'd1);
        chk("wr_m_addr", m_addr, 32'h100);
        chk("wr_m_dtw", m_dtw, 32'h1234_5678);
        wait_ack(1'b1, n);
        chk("wr_latency_rest", n, 4);
        repeat (2) @(negedge clk);
        chk("wr_eack_once", eack_cnt, 1);
        chk("wr_no_fack", fack_cnt, 0);
        chk("wr_stb_cycles", stb_cnt, 3);

        // Execute read
        clr(); mem_data = 32'h0BAD_F00D; ack_delay = 5;
        e_addr = 32'h2000; e_rw = 1'b0; e_reqm = 1'b1;
        wait_ack(1'b1, n);
        chk("rd_latency", n, 8);
        chk("rd_e_dtr", e_dtr, 32'h0BAD_F00D);
        @(negedge clk);

        // Simultaneous requests, three rounds
        order.delete();
        for (int r = 0; r < 3; r++) begin
            clr(); ack_delay = 1; mem_data = 32'hA000_0000 + r;
            e_addr = 32'h200 + r; e_rw = 1'b0; f_addr = 32'h300 + r;
            e_reqm = 1'b1; f_reqm = 1'b1;
            n = 0;
            while (!(eack_cnt >= 1 && fack_cnt >= 1) && n < 40) begin
                @(negedge clk); n++;
            end
            if (n >= 40) begin
                checks++; errs++;
                $display("FAIL tie_round%0d: acks e=%0d f=%0d required 1 each", r, eack_cnt, fack_cnt);
            end
            @(negedge clk);
        end
        chk("tie_order_len", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("tie_order", order[i], (i % 2 == 0) ? 1 : 0);

        // Timeout: no m_ack at all
        clr(); mem_data = 32'h1111_1111; ack_delay = -1;
        e_addr = 32'h400; e_rw = 1'b0; e_reqm = 1'b1;
        wait_ack(1'b1, n);
        chk("tmo_latency", n, 18);
        chk("tmo_bus_err_with_ack", {31'd0, bus_err}, 32'd1);
        chk("tmo_e_dtr", e_dtr, 32'hFFFF_FFFF);
        chk("tmo_stb_cycles", stb_cnt, 16);
        @(negedge clk);
        chk("tmo_berr_once", berr_cnt, 1);

        // m_ack on the last allowed cycle wins
        clr(); mem_data = 32'h7777_8888; ack_delay = WT - 1;
        f_addr = 32'h500; f_reqm = 1'b1;
        wait_ack(1'b0, n);
        chk("edge_latency", n, 18);
        chk("edge_f_dtr", f_dtr, 32'h7777_8888);
        @(negedge clk);
        chk("edge_no_berr", berr_cnt, 0);

        // Flush while a fetch is in BUSY
        clr(); mem_data = 32'h1111_2222; ack_delay = 3;
        f_addr = 32'h40; f_reqm = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        flush = 1'b1; f_reqm = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush_no_fack", fack_cnt, 0);
        chk("flush_f_dtr_kept", f_dtr, 32'h7777_8888);
        chk("flush_stb_cycles", stb_cnt, 4);
        clr(); mem_data = 32'h55AA_55AA; ack_delay = 0;
        f_addr = 32'h44; f_reqm = 1'b1;
        wait_ack(1'b0, n);
        chk("postflush_latency", n, 3);
        chk("postflush_f_dtr", f_dtr, 32'h55AA_55AA);
        @(negedge clk);

        // Flush does not disturb an execute transaction
        clr(); mem_data = 32'h3333_4444; ack_delay = 2;
        e_addr = 32'h600; e_rw = 1'b0; e_reqm = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (6) @(negedge clk);
        chk("eflush_eack", eack_cnt, 1);
        chk("eflush_e_dtr", e_dtr, 32'h3333_4444);

        // Stray m_ack while idle
        clr(); spurious = 1'b1;
        repeat (4) @(negedge clk);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_no_stb", stb_cnt, 0);
        chk("stray_no_ack", fack_cnt + eack_cnt, 0);

        // Asynchronous reset during BUSY
        clr(); mem_data = 32'h9999_0000; ack_delay = -1;
        e_addr = 32'h700; e_rw = 1'b1; e_dtw = 32'h0F0F_0F0F; e_reqm = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        #2 reset_n = 1'b0;
        e_reqm = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clr(); mem_data = 32'hFACE_B00C; ack_delay = 0;
        f_addr = 32'h80; f_reqm = 1'b1;
        wait_ack(1'b0, n);
        chk("postrst_latency", n, 3);
        chk("postrst_f_dtr", f_dtr, 32'hFACE_B00C);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
